// File: rtl/cordic_cos_csr.sv
// Memory-mapped iterative CORDIC sine/cosine unit.
// A write to ANGLE starts a 16-iteration rotation-mode CORDIC, one iteration
// per clock; COS/SIN are updated together on the final iteration.
module cordic_cos_csr #(
  parameter logic [31:0] BASE_ADDR = 32'h00000008,
  parameter int          ITER      = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_bi,
  input  logic [3:0]  bus_be_bi,
  input  logic [31:0] bus_wdata_bi,
  output logic        bus_ack_o,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_bo
);

  localparam int DATA_W = 24;
  localparam logic signed [31:0]     ANG_MAX = 32'sh0001921F;
  localparam logic signed [31:0]     ANG_MIN = -ANG_MAX;
  localparam logic signed [DATA_W-1:0] X_INIT = 24'sh009B75;
  localparam logic [3:0] LAST_ITER = 4'(ITER - 1);

  typedef enum logic {IDLE, RUN} state_t;

  // Clamp a signed Q16 angle to the CORDIC convergence range of +/-pi/2.
  function automatic logic signed [31:0] sat_angle(input logic signed [31:0] a);
    if (a > ANG_MAX)      return ANG_MAX;
    else if (a < ANG_MIN) return ANG_MIN;
    else                  return a;
  endfunction

  // atan(2^-i) in Q16.
  function automatic logic signed [DATA_W-1:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    return 24'sd51472;
      4'd1:    return 24'sd30386;
      4'd2:    return 24'sd16055;
      4'd3:    return 24'sd8150;
      4'd4:    return 24'sd4091;
      4'd5:    return 24'sd2047;
      4'd6:    return 24'sd1024;
      4'd7:    return 24'sd512;
      4'd8:    return 24'sd256;
      4'd9:    return 24'sd128;
      4'd10:   return 24'sd64;
      4'd11:   return 24'sd32;
      4'd12:   return 24'sd16;
      4'd13:   return 24'sd8;
      4'd14:   return 24'sd4;
      default: return 24'sd2;
    endcase
  endfunction

  state_t state_q, state_nxt;
  logic busy, last_iter;

  logic signed [DATA_W-1:0] x_q, y_q, z_q;
  logic signed [DATA_W-1:0] x_nxt, y_nxt, z_nxt;
  logic signed [DATA_W-1:0] x_sh, y_sh;
  logic [3:0]               iter_q;

  logic signed [31:0]       angle_q;
  logic signed [DATA_W-1:0] cos_q, sin_q;
  logic done_q, sat_q, ovr_q;

  logic        resp_p1;
  logic [31:0] rdata_p1;
  logic [31:0] rd_mux;

  logic [31:0] offset;
  logic [1:0]  sel;
  logic        wr, rd, angle_wr, start, drop, ovr_clr;
  logic signed [31:0] wdata_s, angle_clamped;
  logic        angle_sat;
  logic        unused_bits;

  assign offset        = bus_addr_bi - BASE_ADDR;
  assign sel           = offset[3:2];
  assign unused_bits   = ^{offset[31:4], offset[1:0], bus_be_bi};
  assign wr            = bus_req_i & bus_we_i;
  assign rd            = bus_req_i & ~bus_we_i;
  assign angle_wr      = wr && (sel == 2'd0);
  assign start         = angle_wr && !busy;
  assign drop          = angle_wr && busy;
  assign ovr_clr       = wr && (sel == 2'd3) && bus_wdata_bi[3];
  assign wdata_s       = $signed(bus_wdata_bi);
  assign angle_clamped = sat_angle(wdata_s);
  assign angle_sat     = (angle_clamped != wdata_s);

  assign bus_ack_o     = bus_req_i;
  assign bus_resp_o    = resp_p1;
  assign bus_rdata_bo  = rdata_p1;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // FSM next-state: start on an accepted ANGLE write, stop after the last iteration.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy      = (state_q == RUN);
    last_iter = (state_q == RUN) && (iter_q == LAST_ITER);
  end

  // One CORDIC micro-rotation; direction follows the sign of the residual angle.
  always_comb begin
    x_sh = x_q >>> iter_q;
    y_sh = y_q >>> iter_q;
    if (!z_q[DATA_W-1]) begin
      x_nxt = x_q - y_sh;
      y_nxt = y_q + x_sh;
      z_nxt = z_q - atan_lut(iter_q);
    end else begin
      x_nxt = x_q + y_sh;
      y_nxt = y_q - x_sh;
      z_nxt = z_q + atan_lut(iter_q);
    end
  end

  // Datapath load/iterate and result/status registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      angle_q <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (start) begin
        x_q     <= X_INIT;
        y_q     <= '0;
        z_q     <= angle_clamped[DATA_W-1:0];
        iter_q  <= '0;
        angle_q <= angle_clamped;
        sat_q   <= angle_sat;
        done_q  <= 1'b0;
      end else if (busy) begin
        x_q    <= x_nxt;
        y_q    <= y_nxt;
        z_q    <= z_nxt;
        iter_q <= iter_q + 4'd1;
        if (last_iter) begin
          cos_q  <= x_nxt;
          sin_q  <= y_nxt;
          done_q <= 1'b1;
        end
      end
      // A dropped write setting ovr takes priority over a same-cycle clear.
      if (drop)         ovr_q <= 1'b1;
      else if (ovr_clr) ovr_q <= 1'b0;
    end
  end

  // Read data selection from the current (pre-update) register values.
  always_comb begin
    rd_mux = '0;
    case (sel)
      2'd0: rd_mux = angle_q;
      2'd1: rd_mux = {{(32-DATA_W){cos_q[DATA_W-1]}}, cos_q};
      2'd2: rd_mux = {{(32-DATA_W){sin_q[DATA_W-1]}}, sin_q};
      default: rd_mux = {28'd0, ovr_q, sat_q, done_q, busy};
    endcase
  end

  // Read response stage: one cycle after the accepted read, zero otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_p1  <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      resp_p1  <= rd;
      rdata_p1 <= rd ? rd_mux : 32'd0;
    end
  end

endmodule
